mcnay_counter: RTL and testbench

Loadable up-counter for the 16-bit prime-detection datapath. It is loaded with a starting value, then increments by one on each enabled cycle. The controller uses it as the candidate-divisor/iteration counter: it latches a seed value, then steps the count while the detection loop runs. The output is a pure register with no combinational path from the inputs.

---
 rtl/mcnay_counter_pkg.sv | 23 ++
 rtl/mcnay_counter.sv | 45 ++++
 tb/tb_mcnay_counter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mcnay_counter_pkg.sv
// Shared constants and types for the prime-detection iteration counter.
// Holds the datapath width and the per-cycle operation decode.
package mcnay_counter_pkg;

    localparam int unsigned DataWidth = 16;

    typedef enum logic [1:0] {
        OpHold,
        OpInc,
        OpLoad
    } op_e;

    // Load outranks increment; reset is handled separately in the register.
    function automatic op_e decode_op(input logic latch_val, input logic en);
        if (latch_val) begin
            return OpLoad;
        end else if (en) begin
            return OpInc;
        end
        return OpHold;
    endfunction

endpackage

// File: rtl/mcnay_counter.sv
// Loadable up-counter used as the candidate-divisor/iteration counter.
// out_num comes straight from the state register; there is no input-to-output path.
module mcnay_counter
    import mcnay_counter_pkg::*;
#(
    parameter int unsigned nbits = DataWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [nbits-1:0] in_num,
    input  logic             latch_val,
    input  logic             en,
    output logic [nbits-1:0] out_num
);

    logic [nbits-1:0] count_q;
    logic [nbits-1:0] count_d;
    op_e              op;

    always_comb begin
        op = decode_op(latch_val, en);
    end

    // Increment wraps silently from all-ones to zero.
    always_comb begin
        count_d = count_q;
        unique case (op)
            OpLoad:  count_d = in_num;
            OpInc:   count_d = count_q + nbits'(1);
            OpHold:  count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_num = count_q;

endmodule

// File: tb/tb_mcnay_counter.sv
// Scoreboard bench for mcnay_counter: directed plan cases then randomized traffic
// checked against an arithmetic reference model.
module tb_mcnay_counter;

    localparam int unsigned W = 16;
    localparam int unsigned Modulus = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         latch_val = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] in_num = '0;
    logic [W-1:0] out_num;

    int           vectors = 0;
    int           miscompares = 0;
    int           model = 0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] mon_exp;
    string        mon_name;

    mcnay_counter #(.nbits(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_num    (in_num),
        .latch_val (latch_val),
        .en        (en),
        .out_num   (out_num)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the value out_num must show after the edge.
    // want < 0: expectation comes from the model; otherwise a fixed value from the plan.
    task automatic step(input logic r, input logic l, input logic e,
                        input logic [W-1:0] n, input string nm, input int want);
        @(negedge clk);
        rst = r;
        latch_val = l;
        en = e;
        in_num = n;
        if (want >= 0) begin
            model = want;
        end else if (r) begin
            model = 0;
        end else if (l) begin
            model = int'(n);
        end else if (e) begin
            model = (model + 1) % Modulus;
        end
        exp_q.push_back(W'(model));
        name_q.push_back(nm);
    endtask

    // Monitor: every cycle after the edge, compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_name = name_q.pop_front();
            vectors++;
            if (out_num !== mon_exp) begin
                miscompares++;
                $display("FAIL %s: out_num=%h expected %h", mon_name, out_num, mon_exp);
            end
        end
    end

    initial begin
        logic          r_r, r_l, r_e;
        logic [W-1:0]  r_n;
        int unsigned   pick;
        int            waited;

        // Reset wins over load and enable.
        step(1'b1, 1'b1, 1'b1, 16'h1234, "reset", 0);

        // Load then count.
        step(1'b0, 1'b1, 1'b0, 16'd7, "load7", 7);
        step(1'b0, 1'b0, 1'b1, 16'hdead, "inc8", 8);
        step(1'b0, 1'b0, 1'b1, 16'hbeef, "inc9", 9);
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc10", 10);

        // Hold.
        step(1'b0, 1'b1, 1'b0, 16'd100, "load100", 100);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, W'($urandom), "hold100", 100);
        end

        // Load outranks enable.
        step(1'b0, 1'b1, 1'b0, 16'd10, "load10", 10);
        step(1'b0, 1'b1, 1'b1, 16'd50, "priority", 50);

        // Wrap from all-ones.
        step(1'b0, 1'b1, 1'b0, 16'hffff, "loadffff", 16'hffff);
        step(1'b0, 1'b0, 1'b1, 16'h0000, "wrap0", 0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, "wrap1", 1);

        // Reset mid-count.
        step(1'b0, 1'b1, 1'b0, 16'd41, "load41", 41);
        step(1'b0, 1'b0, 1'b1, 16'd0, "inc42", 42);
        step(1'b1, 1'b0, 1'b1, 16'd0, "rst_mid", 0);
        step(1'b0, 1'b0, 1'b1, 16'd0, "after_rst", 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r_r = ($urandom_range(31) == 0);
            r_l = ($urandom_range(3) == 0);
            r_e = ($urandom_range(1) == 0);
            pick = $urandom_range(7);
            case (pick)
                0:       r_n = 16'hffff;
                1:       r_n = 16'hfffe;
                2:       r_n = 16'h0000;
                default: r_n = W'($urandom);
            endcase
            step(r_r, r_l, r_e, r_n, "random", -1);
        end

        @(negedge clk);
        rst = 1'b0;
        latch_val = 1'b0;
        en = 1'b0;

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
